mnist_dot_engine: RTL

- Neuron dot-product engine that sits directly downstream of the AXI/native dual-port weight/activation BRAM and is the sole master of that BRAM's native port B.
- On a start pulse it reads a packed int8 activation vector and a packed int8 weight vector from BRAM.
- It multiply-accumulates them onto a signed bias, optionally applies ReLU, and writes the 32-bit result back into the same BRAM.
- The PS (processor system) then reads the result over AXI.

---
 rtl/mnist_nn_pkg.sv | 19 +
 rtl/mnist_dot_engine_if.sv | 14 +
 rtl/mnist_dot_engine_int8x4_dot.sv | 27 ++
 rtl/mnist_dot_engine.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/mnist_nn_pkg.sv
// Shared constants for the MNIST dot-product engine: FSM encoding,
// int8 lane geometry and the BRAM read latency the FSM is built around.
package mnist_nn_pkg;

  localparam int LANE_W      = 8;
  localparam int LANES       = 4;
  localparam int DOT_W       = 2 * LANE_W + 2;
  localparam int BRAM_RD_LAT = 1;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE  = 3'd0;
  localparam state_t S_RD_X  = 3'd1;
  localparam state_t S_RD_W  = 3'd2;
  localparam state_t S_ACC   = 3'd3;
  localparam state_t S_WRITE = 3'd4;
  localparam state_t S_DONE  = 3'd5;

endpackage

// File: rtl/mnist_dot_engine_if.sv
// Native BRAM port bundle; the engine is the master, the BRAM the slave.
interface mnist_dot_engine_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] din;
  logic [DATA_W-1:0] dout;
  logic              en;
  logic              we;

  modport master (output addr, output din, output en, output we, input dout);
  modport slave  (input addr, input din, input en, input we, output dout);
endinterface

// File: rtl/mnist_dot_engine_int8x4_dot.sv
// Combinational signed dot product of four int8 lanes packed in one word each.
module int8x4_dot
  import mnist_nn_pkg::*;
#(
  parameter int DATA_W = LANES * LANE_W
) (
  input  logic [DATA_W-1:0]       x_word,
  input  logic [DATA_W-1:0]       w_word,
  output logic signed [DOT_W-1:0] dot
);

  logic signed [LANE_W-1:0]   x_lane [LANES];
  logic signed [LANE_W-1:0]   w_lane [LANES];
  logic signed [2*LANE_W-1:0] prod   [LANES];

  // 16-bit products summed in an 18-bit signed adder tree, so no lane can overflow
  always_comb begin
    dot = '0;
    for (int i = 0; i < LANES; i++) begin
      x_lane[i] = x_word[i*LANE_W +: LANE_W];
      w_lane[i] = w_word[i*LANE_W +: LANE_W];
      prod[i]   = x_lane[i] * w_lane[i];
      dot       = dot + {{(DOT_W-2*LANE_W){prod[i][2*LANE_W-1]}}, prod[i]};
    end
  end

endmodule

// File: rtl/mnist_dot_engine.sv
// Neuron engine: reads activation/weight word pairs over BRAM port B,
// accumulates onto a bias, optionally applies ReLU and writes the result back.
module mnist_dot_engine
  import mnist_nn_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int ACC_W  = 32
) (
  input  logic                    s_axi_aclk,
  input  logic                    s_axi_aresetn,
  input  logic                    start,
  input  logic [ADDR_W-1:0]       x_base,
  input  logic [ADDR_W-1:0]       w_base,
  input  logic [ADDR_W-1:0]       len,
  input  logic [ACC_W-1:0]        bias,
  input  logic                    relu_en,
  input  logic [ADDR_W-1:0]       res_addr,
  mnist_dot_engine_if.master      bram_portb,
  output logic                    busy,
  output logic                    done,
  output logic [ACC_W-1:0]        result
);

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  x_base_q, x_base_d;
  logic [ADDR_W-1:0]  w_base_q, w_base_d;
  logic [ADDR_W-1:0]  len_q, len_d;
  logic [ADDR_W-1:0]  res_addr_q, res_addr_d;
  logic               relu_q, relu_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [ADDR_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0]  x_reg_q, x_reg_d;
  logic [ACC_W-1:0]   result_q, result_d;

  logic signed [DOT_W-1:0] dot;
  logic [ADDR_W-1:0]       idx_inc;
  logic [ACC_W-1:0]        wr_val;

  // In ACC the weight word is on dout while the activation sits in x_reg
  int8x4_dot #(.DATA_W(DATA_W)) u_dot (
    .x_word (x_reg_q),
    .w_word (bram_portb.dout),
    .dot    (dot)
  );

  assign idx_inc = idx_q + ADDR_W'(1);
  assign wr_val  = (relu_q && acc_q[ACC_W-1]) ? '0 : acc_q;

  always_comb begin
    state_d    = state_q;
    x_base_d   = x_base_q;
    w_base_d   = w_base_q;
    len_d      = len_q;
    res_addr_d = res_addr_q;
    relu_d     = relu_q;
    acc_d      = acc_q;
    idx_d      = idx_q;
    x_reg_d    = x_reg_q;
    result_d   = result_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          x_base_d   = x_base;
          w_base_d   = w_base;
          len_d      = len;
          res_addr_d = res_addr;
          relu_d     = relu_en;
          acc_d      = bias;
          idx_d      = '0;
          state_d    = (len == '0) ? S_WRITE : S_RD_X;
        end
      end
      S_RD_X: state_d = S_RD_W;
      S_RD_W: begin
        x_reg_d = bram_portb.dout;
        state_d = S_ACC;
      end
      S_ACC: begin
        acc_d   = acc_q + {{(ACC_W-DOT_W){dot[DOT_W-1]}}, dot};
        idx_d   = idx_inc;
        state_d = (idx_inc < len_q) ? S_RD_X : S_WRITE;
      end
      S_WRITE: begin
        result_d = wr_val;
        state_d  = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Port-B strobes decode straight from state so an async reset drops them at once
  always_comb begin
    bram_portb.en   = 1'b0;
    bram_portb.we   = 1'b0;
    bram_portb.addr = '0;
    bram_portb.din  = '0;
    case (state_q)
      S_RD_X: begin
        bram_portb.en   = 1'b1;
        bram_portb.addr = x_base_q + idx_q;
      end
      S_RD_W: begin
        bram_portb.en   = 1'b1;
        bram_portb.addr = w_base_q + idx_q;
      end
      S_WRITE: begin
        bram_portb.en   = 1'b1;
        bram_portb.we   = 1'b1;
        bram_portb.addr = res_addr_q;
        bram_portb.din  = wr_val;
      end
      default: ;
    endcase
  end

  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_DONE);
  assign result = result_q;

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state_q    <= S_IDLE;
      x_base_q   <= '0;
      w_base_q   <= '0;
      len_q      <= '0;
      res_addr_q <= '0;
      relu_q     <= 1'b0;
      acc_q      <= '0;
      idx_q      <= '0;
      x_reg_q    <= '0;
      result_q   <= '0;
    end else begin
      state_q    <= state_d;
      x_base_q   <= x_base_d;
      w_base_q   <= w_base_d;
      len_q      <= len_d;
      res_addr_q <= res_addr_d;
      relu_q     <= relu_d;
      acc_q      <= acc_d;
      idx_q      <= idx_d;
      x_reg_q    <= x_reg_d;
      result_q   <= result_d;
    end
  end

endmodule
